// File: rtl/l1_writeback_buffer_if.sv
// Interface bundling the L1 eviction, L2 writeback and read-forwarding
// signals of the L1 writeback buffer.
interface l1_writeback_buffer_if #(
  parameter int ADDR_WIDTH = 11,
  parameter int DATA_WIDTH = 32
) ();

  logic                  evict_valid;
  logic                  evict_ready;
  logic [ADDR_WIDTH-1:0] evict_addr;
  logic [DATA_WIDTH-1:0] evict_data;

  logic                  wb_valid;
  logic                  wb_ready;
  logic [ADDR_WIDTH-1:0] wb_addr;
  logic [DATA_WIDTH-1:0] wb_data;

  logic [ADDR_WIDTH-1:0] lookup_addr;
  logic                  lookup_hit;
  logic [DATA_WIDTH-1:0] lookup_data;

  // Buffer side: consumes victims and lookups, produces writebacks.
  modport slave (
    input  evict_valid, evict_addr, evict_data, wb_ready, lookup_addr,
    output evict_ready, wb_valid, wb_addr, wb_data, lookup_hit, lookup_data
  );

  // Environment side: L1 eviction source, L2 sink and read path.
  modport master (
    output evict_valid, evict_addr, evict_data, wb_ready, lookup_addr,
    input  evict_ready, wb_valid, wb_addr, wb_data, lookup_hit, lookup_data
  );

endinterface

// File: rtl/l1_writeback_buffer.sv
// L1 writeback buffer: in-order queue of dirty victims drained to L2,
// with coalescing of repeat evictions to non-head entries and
// youngest-match forwarding to the read-miss path.
module l1_writeback_buffer #(
  parameter int ADDR_WIDTH = 11,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  l1_writeback_buffer_if.slave     bus,
  output logic [$clog2(DEPTH):0]   count,
  output logic [31:0]              perf_writebacks,
  output logic [31:0]              perf_coalesced,
  output logic [31:0]              perf_full_stalls
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [DEPTH-1:0]      r_valid;
  logic [ADDR_WIDTH-1:0] r_addr [DEPTH];
  logic [DATA_WIDTH-1:0] r_data [DEPTH];
  logic [PTR_W-1:0]      r_head;
  logic [PTR_W-1:0]      r_tail;
  logic [CNT_W-1:0]      r_count;
  logic                  r_wb_valid;
  logic [31:0]           r_perf_wb;
  logic [31:0]           r_perf_coal;
  logic [31:0]           r_perf_stall;

  logic                  w_coal_hit;
  logic [PTR_W-1:0]      w_coal_idx;
  logic                  w_not_full;
  logic                  w_accept;
  logic                  w_alloc;
  logic                  w_coalesce;
  logic                  w_drain;
  logic                  w_stall;
  logic [CNT_W-1:0]      w_count_nxt;
  logic                  w_lookup_hit;
  logic [DATA_WIDTH-1:0] w_lookup_data;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  // Find a valid non-head entry matching the victim; the head is excluded
  // because its address/data are already committed to the wb port.
  always_comb begin
    w_coal_hit = 1'b0;
    w_coal_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (r_valid[i] && (PTR_W'(i) != r_head) &&
          (r_addr[i] == bus.evict_addr)) begin
        w_coal_hit = 1'b1;
        w_coal_idx = PTR_W'(i);
      end
    end
  end

  // A full buffer still accepts a victim it can merge; wb_ready is
  // deliberately not consulted so acceptance never depends on L2.
  assign w_not_full      = (r_count != FULL_CNT);
  assign bus.evict_ready = w_not_full || w_coal_hit;
  assign w_accept        = bus.evict_valid && bus.evict_ready;
  assign w_alloc         = w_accept && !w_coal_hit;
  assign w_coalesce      = w_accept && w_coal_hit;
  assign w_drain         = r_wb_valid && bus.wb_ready;
  assign w_stall         = bus.evict_valid && !bus.evict_ready;

  // Occupancy after this edge: allocation and drain cancel out.
  always_comb begin
    w_count_nxt = r_count;
    case ({w_alloc, w_drain})
      2'b10:   w_count_nxt = r_count + CNT_W'(1);
      2'b01:   w_count_nxt = r_count - CNT_W'(1);
      default: w_count_nxt = r_count;
    endcase
  end

  // Control state: pointers, valid bits, occupancy, wb_valid and counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid      <= '0;
      r_head       <= '0;
      r_tail       <= '0;
      r_count      <= '0;
      r_wb_valid   <= 1'b0;
      r_perf_wb    <= '0;
      r_perf_coal  <= '0;
      r_perf_stall <= '0;
    end else begin
      if (w_drain) begin
        r_valid[r_head] <= 1'b0;
        r_head          <= r_head + PTR_W'(1);
        r_perf_wb       <= sat_inc(r_perf_wb);
      end
      // Allocation never targets the draining head: allocation needs a
      // free slot, and the tail only meets a valid head when full.
      if (w_alloc) begin
        r_valid[r_tail] <= 1'b1;
        r_tail          <= r_tail + PTR_W'(1);
      end
      if (w_coalesce) begin
        r_perf_coal <= sat_inc(r_perf_coal);
      end
      if (w_stall) begin
        r_perf_stall <= sat_inc(r_perf_stall);
      end
      r_count    <= w_count_nxt;
      r_wb_valid <= (w_count_nxt != '0);
    end
  end

  // Entry payload; left unreset since every reader is gated by r_valid.
  always_ff @(posedge clk) begin
    if (w_alloc) begin
      r_addr[r_tail] <= bus.evict_addr;
      r_data[r_tail] <= bus.evict_data;
    end else if (w_coalesce) begin
      r_data[w_coal_idx] <= bus.evict_data;
    end
  end

  // Forwarding: walk entries oldest to youngest from the head so the
  // youngest match overrides any older duplicate.
  always_comb begin : p_lookup
    logic [PTR_W-1:0] idx;
    w_lookup_hit  = 1'b0;
    w_lookup_data = '0;
    idx           = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = r_head + PTR_W'(k);
      if (r_valid[idx] && (r_addr[idx] == bus.lookup_addr)) begin
        w_lookup_hit  = 1'b1;
        w_lookup_data = r_data[idx];
      end
    end
  end

  assign bus.lookup_hit  = w_lookup_hit;
  assign bus.lookup_data = w_lookup_data;

  assign bus.wb_valid    = r_wb_valid;
  assign bus.wb_addr     = r_addr[r_head];
  assign bus.wb_data     = r_data[r_head];

  assign count            = r_count;
  assign perf_writebacks  = r_perf_wb;
  assign perf_coalesced   = r_perf_coal;
  assign perf_full_stalls = r_perf_stall;

endmodule

// File: tb/tb_l1_writeback_buffer.sv
// Testbench for l1_writeback_buffer: directed scenarios plus randomized
// traffic, all checked against a queue-based reference model.
module tb_l1_writeback_buffer;

  localparam int AW    = 11;
  localparam int DW    = 32;
  localparam int DEPTH = 4;

  logic        clk;
  logic        rst_n;
  logic [2:0]  count;
  logic [31:0] perf_writebacks;
  logic [31:0] perf_coalesced;
  logic [31:0] perf_full_stalls;

  l1_writeback_buffer_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  l1_writeback_buffer #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .bus              (bus),
    .count            (count),
    .perf_writebacks  (perf_writebacks),
    .perf_coalesced   (perf_coalesced),
    .perf_full_stalls (perf_full_stalls)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int nvec  = 0;
  int nfail = 0;

  // Reference model: ordered list of pending writebacks plus counters.
  typedef struct {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } ent_t;
  ent_t        q[$];
  logic [31:0] m_wb, m_coal, m_stall;

  function automatic int m_coal_idx(input logic [AW-1:0] a);
    for (int j = 1; j < q.size(); j++)
      if (q[j].a == a) return j;
    return -1;
  endfunction

  function automatic bit m_ready(input logic [AW-1:0] a);
    return (q.size() < DEPTH) || (m_coal_idx(a) >= 0);
  endfunction

  function automatic void m_lookup(input logic [AW-1:0] a, output bit hit,
                                   output logic [DW-1:0] d);
    hit = 1'b0;
    d   = '0;
    for (int k = q.size() - 1; k >= 0; k--) begin
      if (q[k].a == a) begin
        hit = 1'b1;
        d   = q[k].d;
        return;
      end
    end
  endfunction

  function automatic void m_clear();
    q.delete();
    m_wb = 0; m_coal = 0; m_stall = 0;
  endfunction

  // Advance one clock: update the model from the inputs seen at the edge.
  task automatic tick();
    int j;
    bit rdy, drain;
    j     = m_coal_idx(bus.evict_addr);
    rdy   = (q.size() < DEPTH) || (j >= 0);
    drain = (q.size() != 0) && bus.wb_ready;
    if (bus.evict_valid && !rdy) m_stall++;
    if (bus.evict_valid && rdy && j >= 0) begin
      q[j].d = bus.evict_data;
      m_coal++;
    end
    if (drain) begin
      void'(q.pop_front());
      m_wb++;
    end
    if (bus.evict_valid && rdy && j < 0)
      q.push_back('{a: bus.evict_addr, d: bus.evict_data});
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.evict_valid = 1'b0;
    bus.evict_addr  = '0;
    bus.evict_data  = '0;
    bus.wb_ready    = 1'b0;
    bus.lookup_addr = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    m_clear();
  endtask

  task automatic push(input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.evict_valid = 1'b1;
    bus.evict_addr  = a;
    bus.evict_data  = d;
    tick();
    bus.evict_valid = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    nvec++; if (count !== 3'd0) begin nfail++; $display("FAIL reset_count got=%0d exp=0", count); end
    nvec++; if (bus.wb_valid !== 1'b0) begin nfail++; $display("FAIL reset_wb_valid got=%0b exp=0", bus.wb_valid); end
    nvec++; if (bus.evict_ready !== 1'b1) begin nfail++; $display("FAIL reset_evict_ready got=%0b exp=1", bus.evict_ready); end
    nvec++; if (bus.lookup_hit !== 1'b0) begin nfail++; $display("FAIL reset_lookup_hit got=%0b exp=0", bus.lookup_hit); end
    nvec++; if ({perf_writebacks, perf_coalesced, perf_full_stalls} !== 96'd0) begin
      nfail++; $display("FAIL reset_perf got=%0d/%0d/%0d exp=0/0/0", perf_writebacks, perf_coalesced, perf_full_stalls); end
  endtask

  task automatic test_reset_mid_drain();
    do_reset();
    push(11'h100, 32'h1); push(11'h110, 32'h2); push(11'h120, 32'h3); push(11'h130, 32'h4);
    bus.evict_valid = 1'b1; bus.evict_addr = 11'h140; bus.evict_data = 32'h5;
    tick();                       // one full stall
    bus.evict_valid = 1'b0;
    bus.wb_ready = 1'b1;
    tick();                       // one writeback, 3 left
    bus.lookup_addr = 11'h120;
    #1;
    nvec++; if (count !== 3'd3 || bus.wb_valid !== 1'b1 || bus.lookup_hit !== 1'b1) begin
      nfail++; $display("FAIL middrain_pre count=%0d wbv=%0b hit=%0b exp=3/1/1", count, bus.wb_valid, bus.lookup_hit); end
    rst_n = 1'b0;
    #1;
    nvec++; if (count !== 3'd0) begin nfail++; $display("FAIL middrain_count got=%0d exp=0", count); end
    nvec++; if (bus.wb_valid !== 1'b0) begin nfail++; $display("FAIL middrain_wb_valid got=%0b exp=0", bus.wb_valid); end
    nvec++; if (bus.lookup_hit !== 1'b0 || bus.lookup_data !== 32'd0) begin
      nfail++; $display("FAIL middrain_lookup hit=%0b data=%h exp=0/0", bus.lookup_hit, bus.lookup_data); end
    nvec++; if (bus.evict_ready !== 1'b1) begin nfail++; $display("FAIL middrain_ready got=%0b exp=1", bus.evict_ready); end
    nvec++; if ({perf_writebacks, perf_coalesced, perf_full_stalls} !== 96'd0) begin
      nfail++; $display("FAIL middrain_perf got=%0d/%0d/%0d exp=0/0/0", perf_writebacks, perf_coalesced, perf_full_stalls); end
    do_reset();
  endtask

  task automatic test_fifo_order();
    do_reset();
    push(11'h010, 32'hAAAA_0001);
    push(11'h020, 32'hAAAA_0002);
    #1;
    nvec++; if (count !== 3'd2) begin nfail++; $display("FAIL fifo_count got=%0d exp=2", count); end
    nvec++; if (bus.wb_valid !== 1'b1 || bus.wb_addr !== 11'h010 || bus.wb_data !== 32'hAAAA_0001) begin
      nfail++; $display("FAIL fifo_head0 v=%0b a=%h d=%h exp=1/010/aaaa0001", bus.wb_valid, bus.wb_addr, bus.wb_data); end
    bus.wb_ready = 1'b1;
    tick();
    nvec++; if (bus.wb_addr !== 11'h020 || bus.wb_data !== 32'hAAAA_0002) begin
      nfail++; $display("FAIL fifo_head1 a=%h d=%h exp=020/aaaa0002", bus.wb_addr, bus.wb_data); end
    tick();
    bus.wb_ready = 1'b0;
    #1;
    nvec++; if (count !== 3'd0 || bus.wb_valid !== 1'b0) begin
      nfail++; $display("FAIL fifo_empty count=%0d v=%0b exp=0/0", count, bus.wb_valid); end
    nvec++; if (perf_writebacks !== 32'd2) begin nfail++; $display("FAIL fifo_perf_wb got=%0d exp=2", perf_writebacks); end
  endtask

  task automatic test_coalesce();
    do_reset();
    push(11'h010, 32'hD1);
    push(11'h020, 32'hD2);
    push(11'h020, 32'hD3);
    bus.lookup_addr = 11'h020;
    #1;
    nvec++; if (count !== 3'd2) begin nfail++; $display("FAIL coal_count got=%0d exp=2", count); end
    nvec++; if (perf_coalesced !== 32'd1) begin nfail++; $display("FAIL coal_perf got=%0d exp=1", perf_coalesced); end
    nvec++; if (bus.lookup_hit !== 1'b1 || bus.lookup_data !== 32'hD3) begin
      nfail++; $display("FAIL coal_lookup hit=%0b data=%h exp=1/d3", bus.lookup_hit, bus.lookup_data); end
    bus.wb_ready = 1'b1;
    nvec++; if (bus.wb_addr !== 11'h010 || bus.wb_data !== 32'hD1) begin
      nfail++; $display("FAIL coal_drain0 a=%h d=%h exp=010/d1", bus.wb_addr, bus.wb_data); end
    tick();
    nvec++; if (bus.wb_addr !== 11'h020 || bus.wb_data !== 32'hD3) begin
      nfail++; $display("FAIL coal_drain1 a=%h d=%h exp=020/d3", bus.wb_addr, bus.wb_data); end
    tick();
    bus.wb_ready = 1'b0;
  endtask

  task automatic test_full_stall();
    do_reset();
    push(11'h100, 32'hC0C0_0000); push(11'h110, 32'hC0C0_0001);
    push(11'h120, 32'hC0C0_0002); push(11'h130, 32'hC0C0_0003);
    bus.evict_valid = 1'b1; bus.evict_addr = 11'h140; bus.evict_data = 32'hDEAD_0004;
    for (int c = 0; c < 3; c++) begin
      #1;
      nvec++; if (bus.evict_ready !== 1'b0) begin nfail++; $display("FAIL full_ready cyc=%0d got=%0b exp=0", c, bus.evict_ready); end
      tick();
    end
    nvec++; if (perf_full_stalls !== 32'd3) begin nfail++; $display("FAIL full_stalls got=%0d exp=3", perf_full_stalls); end
    bus.evict_addr = 11'h120; bus.evict_data = 32'hBEEF_0002;
    #1;
    nvec++; if (bus.evict_ready !== 1'b1) begin nfail++; $display("FAIL full_coal_ready got=%0b exp=1", bus.evict_ready); end
    tick();
    bus.evict_valid = 1'b0;
    bus.lookup_addr = 11'h120;
    #1;
    nvec++; if (count !== 3'd4 || perf_coalesced !== 32'd1) begin
      nfail++; $display("FAIL full_coal count=%0d coal=%0d exp=4/1", count, perf_coalesced); end
    nvec++; if (bus.lookup_data !== 32'hBEEF_0002) begin nfail++; $display("FAIL full_coal_data got=%h exp=beef0002", bus.lookup_data); end
    nvec++; if (bus.wb_addr !== 11'h100) begin nfail++; $display("FAIL full_head got=%h exp=100", bus.wb_addr); end
  endtask

  task automatic test_head_evict();
    do_reset();
    push(11'h030, 32'h0000_00D1);
    bus.wb_ready = 1'b1;
    bus.evict_valid = 1'b1; bus.evict_addr = 11'h030; bus.evict_data = 32'h0000_00D2;
    bus.lookup_addr = 11'h030;
    #1;
    nvec++; if (bus.evict_ready !== 1'b1 || bus.wb_data !== 32'hD1) begin
      nfail++; $display("FAIL head_pre ready=%0b wbd=%h exp=1/d1", bus.evict_ready, bus.wb_data); end
    nvec++; if (bus.lookup_data !== 32'hD1) begin nfail++; $display("FAIL head_same_cycle_fwd got=%h exp=d1", bus.lookup_data); end
    tick();
    bus.evict_valid = 1'b0; bus.wb_ready = 1'b0;
    #1;
    nvec++; if (count !== 3'd1 || bus.wb_addr !== 11'h030 || bus.wb_data !== 32'hD2) begin
      nfail++; $display("FAIL head_post count=%0d a=%h d=%h exp=1/030/d2", count, bus.wb_addr, bus.wb_data); end
    nvec++; if (bus.lookup_hit !== 1'b1 || bus.lookup_data !== 32'hD2) begin
      nfail++; $display("FAIL head_fwd hit=%0b d=%h exp=1/d2", bus.lookup_hit, bus.lookup_data); end
    nvec++; if (perf_writebacks !== 32'd1 || perf_coalesced !== 32'd0) begin
      nfail++; $display("FAIL head_perf wb=%0d coal=%0d exp=1/0", perf_writebacks, perf_coalesced); end
  endtask

  task automatic test_back_to_back();
    int ndr;
    do_reset();
    ndr = 0;
    bus.wb_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      bus.evict_valid = 1'b1;
      bus.evict_addr  = 11'h200 + 11'(i);
      bus.evict_data  = 32'h5000_0000 + 32'(i);
      #1;
      nvec++; if (count > 3'd4) begin nfail++; $display("FAIL b2b_count cyc=%0d got=%0d exp<=4", i, count); end
      if (bus.wb_valid) begin
        nvec++; if (bus.wb_addr !== 11'h200 + 11'(ndr)) begin
          nfail++; $display("FAIL b2b_order idx=%0d got=%h exp=%h", ndr, bus.wb_addr, 11'h200 + 11'(ndr)); end
        ndr++;
      end
      tick();
    end
    bus.evict_valid = 1'b0;
    for (int c = 0; c < 20 && ndr < 10; c++) begin
      #1;
      if (bus.wb_valid) begin
        nvec++; if (bus.wb_addr !== 11'h200 + 11'(ndr) || bus.wb_data !== 32'h5000_0000 + 32'(ndr)) begin
          nfail++; $display("FAIL b2b_tail idx=%0d a=%h d=%h", ndr, bus.wb_addr, bus.wb_data); end
        ndr++;
      end
      tick();
    end
    bus.wb_ready = 1'b0;
    #1;
    nvec++; if (ndr !== 10) begin nfail++; $display("FAIL b2b_drained got=%0d exp=10", ndr); end
    nvec++; if (count !== 3'd0 || perf_writebacks !== 32'd10) begin
      nfail++; $display("FAIL b2b_final count=%0d wb=%0d exp=0/10", count, perf_writebacks); end
  endtask

  task automatic test_random();
    bit            e_hit;
    logic [DW-1:0] e_ld;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      bus.evict_valid = ($urandom_range(0, 99) < 60);
      bus.evict_addr  = 11'($urandom_range(0, 5)) << 4;
      bus.evict_data  = $urandom;
      bus.wb_ready    = ($urandom_range(0, 99) < 40);
      bus.lookup_addr = 11'($urandom_range(0, 6)) << 4;
      #1;
      m_lookup(bus.lookup_addr, e_hit, e_ld);
      nvec++; if (bus.evict_ready !== m_ready(bus.evict_addr)) begin
        nfail++; $display("FAIL rnd_ready cyc=%0d got=%0b exp=%0b", c, bus.evict_ready, m_ready(bus.evict_addr)); end
      nvec++; if (count !== 3'(q.size())) begin
        nfail++; $display("FAIL rnd_count cyc=%0d got=%0d exp=%0d", c, count, q.size()); end
      nvec++; if (bus.wb_valid !== (q.size() != 0)) begin
        nfail++; $display("FAIL rnd_wb_valid cyc=%0d got=%0b exp=%0b", c, bus.wb_valid, q.size() != 0); end
      if (q.size() != 0) begin
        nvec++; if (bus.wb_addr !== q[0].a || bus.wb_data !== q[0].d) begin
          nfail++; $display("FAIL rnd_head cyc=%0d got=%h/%h exp=%h/%h", c, bus.wb_addr, bus.wb_data, q[0].a, q[0].d); end
      end
      nvec++; if (bus.lookup_hit !== e_hit || bus.lookup_data !== e_ld) begin
        nfail++; $display("FAIL rnd_lookup cyc=%0d got=%0b/%h exp=%0b/%h", c, bus.lookup_hit, bus.lookup_data, e_hit, e_ld); end
      nvec++; if (perf_writebacks !== m_wb || perf_coalesced !== m_coal || perf_full_stalls !== m_stall) begin
        nfail++; $display("FAIL rnd_perf cyc=%0d got=%0d/%0d/%0d exp=%0d/%0d/%0d", c,
                          perf_writebacks, perf_coalesced, perf_full_stalls, m_wb, m_coal, m_stall); end
      tick();
    end
    idle_inputs();
  endtask

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    m_clear();
    test_reset();
    test_reset_mid_drain();
    test_fifo_order();
    test_coalesce();
    test_full_stall();
    test_head_evict();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule

// File: doc/l1_writeback_buffer.md
Name: l1_writeback_buffer

Overview:
- Write-side counterpart to the L2→L1 / memory→L1 promotion path.
- Accepts dirty victims evicted from L1, holds them in a small in-order queue and drains them downward to L2 over a valid/ready handshake.
- Coalesces repeat evictions to the same address.
- Forwards buffered data to the read path so an L1 miss never returns stale L2/memory data while a writeback is pending.

Parameters:
- ADDR_WIDTH, 11, CPU address width.
- DATA_WIDTH, 32, data word width.
- DEPTH, 4, queue entries; power of two, >= 2.

Ports:
- clk  in  1  single clock; all state updates on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- evict_valid  in  1  L1 presents a dirty victim.
- evict_ready  out  1  buffer accepts the victim this cycle.
- evict_addr  in  ADDR_WIDTH  victim address.
- evict_data  in  DATA_WIDTH  victim data.
- wb_valid  out  1  head entry offered to L2.
- wb_ready  in  1  L2 accepts the head entry.
- wb_addr  out  ADDR_WIDTH  head address.
- wb_data  out  DATA_WIDTH  head data.
- lookup_addr  in  ADDR_WIDTH  read-miss address from CPU/L1.
- lookup_hit  out  1  lookup_addr matches a buffered entry.
- lookup_data  out  DATA_WIDTH  data of the youngest matching entry; 0 when no hit.
- count  out  $clog2(DEPTH)+1  occupied entries.
- perf_writebacks  out  32  completed wb handshakes.
- perf_coalesced  out  32  evictions merged into an existing entry.
- perf_full_stalls  out  32  cycles with evict_valid && !evict_ready.

Behaviour:
- Reset (rst_n low, asynchronous):
  - count=0, head/tail pointers=0, all entry valid bits=0, wb_valid=0, all perf counters=0.
  - Storage data is not reset; it is gated by the valid bits.
  - Reset mid-drain discards all entries immediately; there is no handshake completion.
- Storage: circular queue of DEPTH entries {valid, addr, data}, head pointer and tail pointer; pointers wrap modulo DEPTH.
- wb port:
  - wb_valid = (count != 0); wb_addr and wb_data come from the head entry. All are driven directly from registers, with no combinational path from any input.
  - Once wb_valid is high, wb_addr and wb_data stay stable until wb_valid && wb_ready.
  - On handshake, head advances and the head entry is invalidated.
- Enqueue, evaluated when evict_valid && evict_ready:
  - Coalesce: if evict_addr matches a valid non-head entry, overwrite that entry's data. No allocation; count is unchanged by the enqueue; perf_coalesced += 1.
  - The head entry is never coalesced, because it is committed to the wb port. A match only on the head allocates a new tail entry.
  - Otherwise allocate at tail, tail += 1.
- evict_ready = (count < DEPTH) || (evict_addr matches a valid non-head entry). This is combinational from evict_addr.
  - evict_ready does not depend on wb_ready: a full buffer does not accept a non-coalescing victim in the same cycle the head drains.
- Simultaneous allocate and drain: count unchanged.
  - Coalesce and drain in the same cycle: count -= 1.
  - Evict addr == head addr while the head drains: new entry allocated; the drained head carries the old data.
- Latency: a victim accepted into an empty buffer at edge N appears on wb_valid/wb_addr/wb_data after edge N (visible in cycle N+1). Minimum residency is 1 cycle.
- Ordering: strict FIFO drain; coalesced data leaves at the original entry's position.
- Forwarding is purely combinational over all valid entries.
  - With duplicates (head plus younger), the youngest entry wins.
  - Forwarding does not reflect an enqueue in the same cycle (its data is visible next cycle).
- Counters: 32-bit, saturating at 32'hFFFF_FFFF (no wrap).
  - perf_writebacks += 1 per wb handshake.
  - perf_full_stalls += 1 per cycle with evict_valid && !evict_ready.
- count is always in 0..DEPTH; it never overflows or underflows.

Test Plan:
1. Reset then idle → count=0, wb_valid=0, evict_ready=1, lookup_hit=0, all perf counters 0; assert rst_n low mid-drain with 3 entries → outputs return to reset values immediately.
2. Enqueue {0x010,0xAAAA0001}, {0x020,0xAAAA0002} with wb_ready=0 → count=2, wb_addr=0x010; raise wb_ready → 0x010 then 0x020 drain in order, perf_writebacks=2, count=0.
3. Enqueue 0x010/D1, 0x020/D2, then 0x020/D3 with wb_ready=0 → count=2, perf_coalesced=1, lookup_addr=0x020 gives lookup_hit=1, lookup_data=D3; 0x010 drains first, then 0x020 with D3.
4. Fill 4 distinct addresses with wb_ready=0, hold a 5th distinct victim for 3 cycles → evict_ready=0, perf_full_stalls=3; a coalescing victim to entry 2 is accepted while full.
5. Head=0x030/D1 with wb_ready=1, evict 0x030/D2 in the same cycle → D1 drains, new entry 0x030/D2 allocated, count stays 1, lookup_data=D2 next cycle.
6. Continuous enqueue/drain for 10 entries with DEPTH=4 → pointer wrap correct, FIFO order preserved, count never exceeds 4.
